// File: rtl/edge_event_stamper.sv
// edge_event_stamper: timestamps qualified edge pulses, tags them with a sequence number and queues them FWFT.
// Latency: accept in cycle t -> head visible with m_valid=1 in cycle t+1; holdoff gives N dead cycles after an accept.
// Backpressure: m_ready stalls the head; accepts into a full queue are dropped and counted. Optional `EDGE_EVENT_STAMPER_RATE_EN adds rate_count.

module fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_n;
  logic [LW-1:0]    level_n;
  logic             push;
  logic             pop;

  // Fullness uses the registered level, so a pop never frees room for a same-cycle push.
  assign wr_rdy  = (level != LW'(DEPTH));
  assign rd_vld  = (level != '0);
  assign push    = wr_vld && wr_rdy;
  assign pop     = rd_vld && rd_rdy;
  assign rptr_n  = rptr + AW'(pop);
  assign level_n = level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_dat;
    end
  end

  // Head register tracks the entry at the next read pointer; it bypasses the array when that entry is being written now.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      rd_dat <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      rptr  <= rptr_n;
      level <= level_n;
      if (level_n != '0) begin
        rd_dat <= (push && (rptr_n == wptr)) ? wr_dat : mem[rptr_n];
      end
    end
  end

endmodule

module edge_event_stamper #(
  parameter int TS_WIDTH      = 48,
  parameter int DEPTH         = 8,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int RATE_LOG2     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pulse_in,
  input  logic                     enable,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic                     ts_clear,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [TS_WIDTH-1:0]      m_timestamp,
  output logic [15:0]              m_seq,
  output logic                     m_overrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count,
  output logic                     busy
`ifdef EDGE_EVENT_STAMPER_RATE_EN
  ,
  output logic [15:0]              rate_count
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (RATE_LOG2 < 1 || RATE_LOG2 > 30) begin : g_bad_rate_log2
    $error("RATE_LOG2 must be in 1..30");
  end

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [15:0]         seq;
    logic                ovr;
  } evt_t;

  typedef enum logic {
    IDLE,
    HOLDOFF
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [TS_WIDTH-1:0]      ts_q;
  logic [TS_WIDTH-1:0]      ts_now;
  logic [HOLDOFF_WIDTH-1:0] hcnt;
  logic [15:0]              seq;
  logic                     pend_ovr;
  logic                     accept;
  logic                     fifo_rdy;
  evt_t                     wr_evt;
  evt_t                     head_evt;

  // ts_clear takes effect in its own cycle: a pulse then stamps 0 and the counter reads 1 next cycle.
  assign ts_now = ts_clear ? '0 : ts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_now + TS_WIDTH'(1);
    end
  end

  assign accept = (state == IDLE) && pulse_in && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && (holdoff != '0)) begin
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hcnt == HOLDOFF_WIDTH'(1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == HOLDOFF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
    end else if (accept) begin
      hcnt <= holdoff;
    end else if (state == HOLDOFF) begin
      hcnt <= hcnt - HOLDOFF_WIDTH'(1);
    end
  end

  // pend_ovr marks the next successfully queued event as following a loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq        <= '0;
      pend_ovr   <= 1'b0;
      drop_count <= '0;
    end else if (accept) begin
      if (fifo_rdy) begin
        seq      <= seq + 16'd1;
        pend_ovr <= 1'b0;
      end else begin
        pend_ovr <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  assign wr_evt.ts  = ts_now;
  assign wr_evt.seq = seq;
  assign wr_evt.ovr = pend_ovr;

  fwft_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (accept),
    .wr_dat (wr_evt),
    .wr_rdy (fifo_rdy),
    .rd_vld (m_valid),
    .rd_rdy (m_ready),
    .rd_dat (head_evt),
    .level  (level)
  );

  assign m_timestamp = head_evt.ts;
  assign m_seq       = head_evt.seq;
  assign m_overrun   = head_evt.ovr;

`ifdef EDGE_EVENT_STAMPER_RATE_EN
  logic [RATE_LOG2-1:0] win;
  logic [15:0]          rate_acc;
  logic [15:0]          rate_inc;
  logic                 win_last;

  assign win_last = &win;
  assign rate_inc = (accept && (rate_acc != 16'hFFFF)) ? rate_acc + 16'd1 : rate_acc;

  // Count includes an accept in the window's last cycle; the next window starts from that cycle's accept only.
  always_ff @(posedge clk) begin
    if (reset) begin
      win        <= '0;
      rate_acc   <= '0;
      rate_count <= '0;
    end else begin
      win <= win + RATE_LOG2'(1);
      if (win_last) begin
        rate_count <= rate_inc;
        rate_acc   <= {15'd0, accept};
      end else begin
        rate_acc <= rate_inc;
      end
    end
  end
`endif

endmodule
